// File: rtl/link_tx_word_gen.sv
// Serializer word source: training pattern, idle gap, then handshaked payload words.
// Optional PRBS7 training pattern is compiled in when LINK_TX_PRBS_EN is defined.

module link_tx_word_gen #(
    parameter logic [7:0]  IDLE_WORD = 8'hAC,
    parameter int unsigned GAP_LEN   = 4
) (
    input  logic        clk160,
    input  logic        rst,
    input  logic        tx_enable,
    input  logic        train_start,
    input  logic [15:0] train_len,
    input  logic [1:0]  pattern_sel,
    input  logic [7:0]  data_in,
    input  logic        data_valid,
    output logic        data_ready,
    output logic [7:0]  d_out,
    output logic        tx_busy,
    output logic        train_done,
    output logic [15:0] words_sent,
    input  logic        reset_counters
);

    typedef enum logic [1:0] {StIdle, StTrain, StGap, StData} state_e;

    state_e      state_q, state_d;
    logic [2:0]  start_sync_q;
    logic [15:0] train_cnt_q, train_cnt_d;
    logic [15:0] gap_cnt_q, gap_cnt_d;
    logic [1:0]  pattern_q, pattern_d;
    logic [7:0]  d_out_q, d_out_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic [15:0] words_sent_q;
    logic        train_req, start_train, xfer;
    logic [7:0]  pattern_word, prbs_word;

    assign train_req   = (start_sync_q == 3'b001);
    assign start_train = train_req && (state_q == StIdle || state_q == StData);
    assign xfer        = data_valid && data_ready;

`ifdef LINK_TX_PRBS_EN
    logic [6:0] lfsr_q, lfsr_d, lfsr_adv;

    // x^7+x^6+1, eight steps per word; the oldest bit leaves first and lands in bit 7.
    always_comb begin
        lfsr_adv  = lfsr_q;
        prbs_word = '0;
        for (int i = 7; i >= 0; i--) begin
            prbs_word[i] = lfsr_adv[6];
            lfsr_adv     = {lfsr_adv[5:0], lfsr_adv[6] ^ lfsr_adv[5]};
        end
    end

    always_comb begin
        lfsr_d = lfsr_q;
        if (start_train) begin
            lfsr_d = 7'h7F;
        end else if (state_q == StTrain) begin
            lfsr_d = lfsr_adv;
        end
    end

    always_ff @(posedge clk160) begin
        if (rst) begin
            lfsr_q <= 7'h7F;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end
`else
    assign prbs_word = 8'h55;
`endif

    always_comb begin
        unique case (pattern_q)
            2'b00:   pattern_word = 8'h55;
            2'b01:   pattern_word = 8'hF0;
            2'b10:   pattern_word = prbs_word;
            default: pattern_word = 8'h33;
        endcase
    end

    assign data_ready = !rst && (state_q == StData) && tx_enable && !train_req;

    always_comb begin
        state_d     = state_q;
        train_cnt_d = train_cnt_q;
        gap_cnt_d   = gap_cnt_q;
        pattern_d   = pattern_q;
        d_out_d     = IDLE_WORD;
        busy_d      = 1'b0;
        done_d      = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (tx_enable) begin
                    state_d = StData;
                end
            end
            StTrain: begin
                d_out_d     = pattern_word;
                busy_d      = 1'b1;
                train_cnt_d = train_cnt_q - 16'd1;
                if (train_cnt_q == 16'd1) begin
                    state_d   = StGap;
                    gap_cnt_d = '0;
                end
            end
            StGap: begin
                busy_d    = 1'b1;
                gap_cnt_d = gap_cnt_q + 16'd1;
                if (gap_cnt_q == 16'(GAP_LEN - 1)) begin
                    done_d    = 1'b1;
                    gap_cnt_d = '0;
                    state_d   = tx_enable ? StData : StIdle;
                end
            end
            default: begin
                if (!tx_enable) begin
                    state_d = StIdle;
                end else if (xfer) begin
                    d_out_d = data_in;
                end
            end
        endcase

        // Retraining overrides anything the IDLE/DATA branches decided.
        if (start_train) begin
            pattern_d = pattern_sel;
            d_out_d   = IDLE_WORD;
            if (train_len == 16'd0) begin
                state_d   = StGap;
                gap_cnt_d = '0;
            end else begin
                state_d     = StTrain;
                train_cnt_d = train_len;
            end
        end
    end

    always_ff @(posedge clk160) begin
        if (rst) begin
            state_q      <= StIdle;
            start_sync_q <= 3'b000;
            train_cnt_q  <= '0;
            gap_cnt_q    <= '0;
            pattern_q    <= 2'b00;
            d_out_q      <= IDLE_WORD;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            words_sent_q <= '0;
        end else begin
            state_q      <= state_d;
            start_sync_q <= {start_sync_q[1:0], train_start};
            train_cnt_q  <= train_cnt_d;
            gap_cnt_q    <= gap_cnt_d;
            pattern_q    <= pattern_d;
            d_out_q      <= d_out_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            if (reset_counters) begin
                words_sent_q <= '0;
            end else if (xfer && words_sent_q != 16'hFFFF) begin
                words_sent_q <= words_sent_q + 16'd1;
            end
        end
    end

    // Status flags are registered alongside d_out so they frame the words actually on the wire.
    assign d_out      = d_out_q;
    assign tx_busy    = busy_q;
    assign train_done = done_q;
    assign words_sent = words_sent_q;

endmodule

// File: tb/tb_link_tx_word_gen.sv
// Scoreboard bench for link_tx_word_gen: stimulus pushes expected words, a monitor pops them.
// Define LINK_TX_PRBS_EN for the bench as well when the DUT is built with PRBS7 enabled.

module tb_link_tx_word_gen;

    localparam logic [7:0] IDLE = 8'hAC;
    localparam int         GAP  = 4;

    logic        clk160 = 1'b0;
    logic        rst = 1'b1;
    logic        tx_enable = 1'b0;
    logic        train_start = 1'b0;
    logic [15:0] train_len = '0;
    logic [1:0]  pattern_sel = '0;
    logic [7:0]  data_in = '0;
    logic        data_valid = 1'b0;
    logic        data_ready;
    logic [7:0]  d_out;
    logic        tx_busy;
    logic        train_done;
    logic [15:0] words_sent;
    logic        reset_counters = 1'b0;

    always #5 clk160 = ~clk160;

    link_tx_word_gen #(.IDLE_WORD(IDLE), .GAP_LEN(GAP)) dut (
        .clk160        (clk160),
        .rst           (rst),
        .tx_enable     (tx_enable),
        .train_start   (train_start),
        .train_len     (train_len),
        .pattern_sel   (pattern_sel),
        .data_in       (data_in),
        .data_valid    (data_valid),
        .data_ready    (data_ready),
        .d_out         (d_out),
        .tx_busy       (tx_busy),
        .train_done    (train_done),
        .words_sent    (words_sent),
        .reset_counters(reset_counters)
    );

    int          checks = 0;
    int          errors = 0;
    int          done_cnt = 0;
    int          done_before = 0;
    bit          xfer_prev = 1'b0;
    logic [7:0]  train_q[$];
    logic [7:0]  pay_q[$];
    logic [15:0] mdl_ws = '0;
    bit          prbs_bits[0:1279];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s: actual=missing required=present (t=%0t)", name, $time);
    endtask

    task automatic tick();
        @(posedge clk160);
        #1;
    endtask

    // Training word idx of a sequence with pattern sel, from the pattern table / PRBS bit stream.
    function automatic logic [7:0] exp_word(input logic [1:0] sel, input int idx);
        logic [7:0] w;
        case (sel)
            2'b00:   w = 8'h55;
            2'b01:   w = 8'hF0;
            2'b11:   w = 8'h33;
            default: begin
`ifdef LINK_TX_PRBS_EN
                for (int j = 0; j < 8; j++) w[7-j] = prbs_bits[8*idx + j];
`else
                w = 8'h55;
`endif
            end
        endcase
        return w;
    endfunction

    // Monitor: every cycle d_out is a payload word, a training/gap word, or the idle word.
    always @(negedge clk160) begin
        if (rst) begin
            xfer_prev = 1'b0;
        end else begin
            if (train_done) done_cnt++;
            if (xfer_prev) begin
                if (pay_q.size() == 0) fail_now("payload_extra");
                else chk("payload_word", d_out, pay_q.pop_front());
            end else if (tx_busy) begin
                if (train_q.size() == 0) fail_now("train_extra");
                else chk("train_word", d_out, train_q.pop_front());
            end else begin
                chk("idle_word", d_out, IDLE);
            end
            xfer_prev = data_valid && data_ready;
        end
    end

    task automatic do_reset();
        data_valid = 1'b0;
        train_start = 1'b0;
        rst = 1'b1;
        tick();
        tick();
        train_q.delete();
        pay_q.delete();
        mdl_ws = '0;
        rst = 1'b0;
    endtask

    task automatic start_train(input int len, input logic [1:0] sel);
        for (int i = 0; i < len; i++) train_q.push_back(exp_word(sel, i));
        for (int i = 0; i < GAP; i++) train_q.push_back(IDLE);
        done_before = done_cnt;
        train_len = 16'(len);
        pattern_sel = sel;
        train_start = 1'b1;
    endtask

    task automatic finish_train(input int len);
        int budget = len + GAP + 20;
        train_start = 1'b0;
        while (budget > 0 && !(train_q.size() == 0 && !tx_busy)) begin
            tick();
            budget--;
        end
        chk("train_words_left", train_q.size(), 0);
        chk("train_done_pulses", done_cnt, done_before + 1);
    endtask

    task automatic send(input int n, input bit gaps, input bit ramp, input logic [7:0] base);
        int got = 0;
        int budget = n * 4 + 20;
        while (got < n && budget > 0) begin
            data_valid = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
            data_in = ramp ? 8'(base + got) : 8'($urandom);
            #1;
            if (data_valid && data_ready) begin
                pay_q.push_back(data_in);
                got++;
                if (mdl_ws != 16'hFFFF) mdl_ws++;
            end
            tick();
            budget--;
        end
        data_valid = 1'b0;
        if (got < n) fail_now("send_timeout");
    endtask

    initial begin
        for (int i = 0; i < 7; i++) prbs_bits[i] = 1'b1;
        for (int k = 0; k + 7 < 1280; k++) prbs_bits[k+7] = prbs_bits[k] ^ prbs_bits[k+1];

        // Reset and quiet idle.
        tick();
        tick();
        tick();
        rst = 1'b0;
        chk("reset_d_out", d_out, IDLE);
        chk("reset_data_ready", data_ready, 0);
        chk("reset_tx_busy", tx_busy, 0);
        chk("reset_train_done", train_done, 0);
        chk("reset_words_sent", words_sent, 0);
        repeat (6) tick();
        chk("idle_data_ready", data_ready, 0);

        // Training 10 x F0 with payload disabled.
        start_train(10, 2'b01);
        tick();
        tick();
        finish_train(10);
        chk("after_train_ready", data_ready, 0);

        // Payload ramp 01..05, then a valid gap.
        tx_enable = 1'b1;
        send(5, 1'b0, 1'b1, 8'h01);
        repeat (3) tick();
        chk("words_sent_5", words_sent, mdl_ws);
        chk("words_sent_5_abs", words_sent, 5);

        // Retrain in DATA while a word is offered on the recognition cycle.
        start_train(3, 2'b00);
        tick();
        data_valid = 1'b1;
        data_in = 8'h77;
        #1;
        chk("retrain_ready_low", data_ready, 0);
        tick();
        data_valid = 1'b0;
        chk("retrain_words_sent", words_sent, mdl_ws);
        finish_train(3);

        // Randomized training/payload mix, including zero-length training.
        for (int it = 0; it < 10; it++) begin
            int   len;
            logic en;
            len = (it == 0) ? 0 : $urandom_range(1, 40);
            en = 1'($urandom_range(0, 1));
            tx_enable = en;
            start_train(len, 2'($urandom_range(0, 3)));
            tick();
            tick();
            finish_train(len);
            if (en) send($urandom_range(1, 10), 1'b1, 1'b0, 8'h00);
            else repeat (3) tick();
            chk("rand_words_sent", words_sent, mdl_ws);
        end

        // Full PRBS7 period (or 0x55 when PRBS is compiled out).
        tx_enable = 1'b0;
        repeat (3) tick();
        start_train(127, 2'b10);
        tick();
        tick();
        finish_train(127);

        // Abort mid-TRAIN.
        start_train(50, 2'b01);
        repeat (12) tick();
        do_reset();
        chk("abort_train_busy", tx_busy, 0);
        chk("abort_train_d_out", d_out, IDLE);
        repeat (60) tick();

        // Abort mid-DATA with a word offered.
        tx_enable = 1'b1;
        send(4, 1'b1, 1'b0, 8'h00);
        data_valid = 1'b1;
        rst = 1'b1;
        #1;
        chk("reset_ready_low", data_ready, 0);
        do_reset();
        chk("abort_data_words_sent", words_sent, 0);
        repeat (5) tick();

        // Saturation and clear-wins-over-increment.
        send(65534, 1'b0, 1'b0, 8'h00);
        chk("words_sent_fffe", words_sent, 16'hFFFE);
        send(3, 1'b0, 1'b0, 8'h00);
        chk("words_sent_sat", words_sent, 16'hFFFF);
        data_valid = 1'b1;
        data_in = 8'h5A;
        reset_counters = 1'b1;
        #1;
        chk("clear_xfer_ready", data_ready, 1);
        if (data_ready) pay_q.push_back(8'h5A);
        mdl_ws = '0;
        tick();
        reset_counters = 1'b0;
        data_valid = 1'b0;
        chk("words_sent_cleared", words_sent, mdl_ws);

        // Drain.
        tx_enable = 1'b0;
        repeat (5) tick();
        chk("payload_drain", pay_q.size(), 0);
        chk("train_drain", train_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/link_tx_word_gen.md
LINK_TX_WORD_GEN -- requirements
Module: link_tx_word_gen

Interface
REQ-001 Parameter IDLE_WORD, default 8'hAC: word driven on d_out whenever no training or payload word is sent.
REQ-002 Parameter GAP_LEN, default 4: number of idle words inserted between the end of training and the start of payload.
REQ-003 clk160  in  1  single clock for all logic.
REQ-004 rst  in  1  reset; synchronous, active-high.
REQ-005 tx_enable  in  1  level; 1 = payload transfer is permitted.
REQ-006 train_start  in  1  asynchronous-source request; the block acts on its rising edge.
REQ-007 train_len  in  16  number of training words to send; sampled on train_start.
REQ-008 pattern_sel  in  2  training pattern: 00=8'h55, 01=8'hF0, 10=PRBS7, 11=8'h33.
REQ-009 data_in  in  8  payload word.
REQ-010 data_valid  in  1  payload word available.
REQ-011 data_ready  out  1  block accepts data_in this cycle.
REQ-012 d_out  out  8  parallel word to the serializer; bit 7 is transmitted first.
REQ-013 tx_busy  out  1  high in TRAIN or GAP.
REQ-014 train_done  out  1  one-cycle pulse on the GAP->DATA or GAP->IDLE transition.
REQ-015 words_sent  out  16  saturating count of accepted payload words.
REQ-016 reset_counters  in  1  synchronous clear of words_sent.

Function
REQ-017 train_start SHALL pass through a 3-bit shift register; a request SHALL be recognised only when the register equals 3'b001.
REQ-018 States SHALL be IDLE, TRAIN, GAP and DATA, encoded in 2 bits.
REQ-019 IDLE: a recognised request SHALL latch train_len and pattern_sel and go to TRAIN (or to GAP if train_len==0); otherwise tx_enable=1 SHALL go to DATA.
REQ-020 TRAIN SHALL emit exactly train_len pattern words; a 16-bit down-counter SHALL reach 0 on the last word, then the state SHALL go to GAP.
REQ-021 GAP SHALL emit GAP_LEN copies of IDLE_WORD, then go to DATA if tx_enable=1, else to IDLE; train_done SHALL pulse on that exit.
REQ-022 DATA: data_ready SHALL be 1; a transfer occurs when data_valid && data_ready, and data_in SHALL appear on d_out exactly 1 cycle later.
REQ-023 DATA with no transfer SHALL emit IDLE_WORD on the next cycle.
REQ-024 DATA with tx_enable=0 SHALL go to IDLE; data_ready SHALL be 0 in that same cycle.
REQ-025 A recognised request in DATA SHALL force TRAIN; data_ready SHALL be 0 in that cycle and no word SHALL be accepted (retrain has priority).
REQ-026 A recognised request in TRAIN or GAP SHALL be ignored.
REQ-027 data_ready SHALL be 0 in IDLE, TRAIN and GAP.
REQ-028 d_out SHALL be registered; every word SHALL appear 1 cycle after its state/counter decision.
REQ-029 words_sent SHALL increment by 1 per transfer, hold at 16'hFFFF, and clear when reset_counters=1; clear SHALL win over increment in the same cycle.
REQ-030 PRBS7 SHALL use x^7+x^6+1, be seeded to 7'h7F on TRAIN entry, and advance 8 steps per word; the first generated bit SHALL map to d_out[7].

Reset
REQ-031 rst=1 SHALL force: state=IDLE, d_out=IDLE_WORD, data_ready=0, tx_busy=0, train_done=0, words_sent=0, all counters=0, LFSR=7'h7F, shift register=3'b000.
REQ-032 rst asserted mid-TRAIN or mid-DATA SHALL abort with no further pattern or payload words; after release the block SHALL behave as out of reset.

Configuration
REQ-033 Macro LINK_TX_PRBS_EN: when defined, the PRBS7 generator SHALL be compiled in and pattern_sel=10 SHALL select it.
REQ-034 When LINK_TX_PRBS_EN is undefined, no LFSR logic SHALL exist and pattern_sel=10 SHALL emit 8'h55.

Verification
REQ-035 rst, then idle with tx_enable=0 -> d_out=8'hAC steady; data_ready=0; words_sent=0.
REQ-036 train_start rising edge, train_len=10, pattern_sel=01 -> exactly 10 words of 8'hF0, then 4 words of 8'hAC, train_done 1-cycle pulse, tx_busy high throughout.
REQ-037 DATA, data_valid=1 with words 8'h01..8'h05 -> d_out 8'h01..8'h05 one cycle later; words_sent=5; a data_valid gap produces 8'hAC.
REQ-038 train_start edge in DATA while data_valid=1 -> data_ready=0 that cycle, word not accepted, words_sent unchanged, TRAIN begins.
REQ-039 PRBS7 (macro defined), train_len=127 -> 127 words whose bit stream repeats with period 127 and first word 8'hFE; macro undefined -> 127 words of 8'h55.
REQ-040 words_sent preloaded to 16'hFFFE, 3 transfers -> 16'hFFFF held; reset_counters during a transfer -> 0.
